// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the LED reaction game round controller:
//   - state_e     : round-sequencing states (PLAY, DARK, WIN)
//   - *_CYCLES_DEF: default timing constants, in 512 Hz game-clock cycles
//   - PAT0..PAT3  : leds_ctrl patterns stepped through during PLAY
//   - WIN_PAT     : leds_ctrl pattern held during the win celebration
//   - DARK_PAT    : leds_ctrl pattern while waiting in the dark
package game_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    DARK = 2'd1,
    WIN  = 2'd2
  } state_e;

  localparam int PLAY_CYCLES_DEF  = 512;
  localparam int WIN_CYCLES_DEF   = 1024;
  localparam int STEP_CYCLES_DEF  = 128;
  localparam int BLINK_CYCLES_DEF = 64;
  localparam int CNT_W_DEF        = 11;

  localparam logic [1:0] PAT0     = 2'b00;
  localparam logic [1:0] PAT1     = 2'b01;
  localparam logic [1:0] PAT2     = 2'b10;
  localparam logic [1:0] PAT3     = 2'b11;
  localparam logic [1:0] WIN_PAT  = 2'b11;
  localparam logic [1:0] DARK_PAT = 2'b00;

endpackage

// File: rtl/state_timer.sv
// state_timer
// Loadable / clearable up-counter with a terminal-count compare.
// Ports:
//   clk        : game clock, rising edge
//   rst        : asynchronous active-low reset, count -> 0
//   clear_i    : synchronous clear to 0 (highest priority)
//   load_i     : synchronous load of load_val_i
//   en_i       : count enable (count holds when low)
//   load_val_i : value loaded when load_i is high
//   tc_val_i   : terminal-count compare value
//   cnt_o      : current count
//   tc_o       : high while cnt_o == tc_val_i
module state_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over load, load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/top_game.sv
// top_game
// Round-sequencing controller for the LED reaction game. Runs a timed
// LED play sequence, waits dark for a won round, then blinks a win
// celebration before starting the next round.
// Ports:
//   clk       : 512 Hz game clock, rising edge
//   rst       : asynchronous active-low reset
//   winrnd    : round-won level from the game logic (sync to clk)
//   clr       : one-cycle clear pulse to the external round timer,
//               high for the first cycle spent in DARK
//   leds_on   : LED enable
//   leds_ctrl : LED pattern select
module top_game
  import game_pkg::*;
#(
  parameter int PLAY_CYCLES  = PLAY_CYCLES_DEF,
  parameter int WIN_CYCLES   = WIN_CYCLES_DEF,
  parameter int STEP_CYCLES  = STEP_CYCLES_DEF,
  parameter int BLINK_CYCLES = BLINK_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       winrnd,
  output logic       clr,
  output logic       leds_on,
  output logic [1:0] leds_ctrl
);

  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic             clr_q;
  logic             clr_d;
  logic [CNT_W-1:0] cnt;
  logic             timerTc;
  logic             timerClear;
  logic             timerEn;
  logic [CNT_W-1:0] tcVal;

  // The terminal value depends on which timed state we are in; DARK has
  // no timeout so its compare value is never acted on.
  always_comb begin
    tcVal = PLAY_LAST;
    if (state_q == WIN) begin
      tcVal = WIN_LAST;
    end
  end

  // Timer restarts from 0 on every state change. It is frozen in DARK,
  // where it sits at the 0 it was cleared to on entry.
  assign timerClear = (state_d != state_q);
  assign timerEn    = (state_q != DARK);

  state_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timerClear),
    .load_i    (1'b0),
    .en_i      (timerEn),
    .load_val_i('0),
    .tc_val_i  (tcVal),
    .cnt_o     (cnt),
    .tc_o      (timerTc)
  );

  // Next-state logic; winrnd only matters while waiting in DARK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLAY: if (timerTc) state_d = DARK;
      DARK: if (winrnd)  state_d = WIN;
      WIN:  if (timerTc) state_d = PLAY;
      default: state_d = PLAY;
    endcase
  end

  // clr is registered so it is a clean pulse covering exactly the first
  // DARK cycle.
  assign clr_d = (state_q == PLAY) && (state_d == DARK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PLAY;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign clr = clr_q;

  // Moore decode of the LED outputs from state and timer.
  always_comb begin
    leds_on   = 1'b1;
    leds_ctrl = PAT0;
    unique case (state_q)
      PLAY: begin
        leds_on   = 1'b1;
        leds_ctrl = 2'((32'(cnt) / STEP_CYCLES) % 4);
      end
      DARK: begin
        leds_on   = 1'b0;
        leds_ctrl = DARK_PAT;
      end
      WIN: begin
        leds_ctrl = WIN_PAT;
        leds_on   = (((32'(cnt) / BLINK_CYCLES) % 2) == 0);
      end
      default: begin
        leds_on   = 1'b1;
        leds_ctrl = PAT0;
      end
    endcase
  end

endmodule

// File: tb/tb_top_game.sv
// tb_top_game
// Directed bench for top_game. Inputs are driven and outputs sampled 1 ns
// after the rising edge. "Cycle k" below means the sample taken after the
// k-th rising edge since the relevant event (reset release / state entry).
module tb_top_game;

  logic       clk;
  logic       rst;
  logic       winrnd;
  logic       clr;
  logic       leds_on;
  logic [1:0] leds_ctrl;

  int checks = 0;
  int errors = 0;

  top_game dut (
    .clk      (clk),
    .rst      (rst),
    .winrnd   (winrnd),
    .clr      (clr),
    .leds_on  (leds_on),
    .leds_ctrl(leds_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare {clr, leds_on, leds_ctrl} against the expected vector.
  task automatic checkOutput(input string tag, input logic expClr,
                             input logic expOn, input logic [1:0] expCtrl);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {clr, leds_on, leds_ctrl};
    exp = {expClr, expOn, expCtrl};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed clr/on/ctrl=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b0;
    winrnd = 1'b0;

    // Reset held: PLAY outputs, no clr.
    tick(3);
    checkOutput("in_reset", 1'b0, 1'b1, 2'b00);

    // Release and walk the first PLAY; winrnd pulses mid-PLAY are ignored.
    rst = 1'b1;
    #1;
    checkOutput("play_c0", 1'b0, 1'b1, 2'b00);
    tick(127);
    checkOutput("play_c127", 1'b0, 1'b1, 2'b00);
    tick(1);
    checkOutput("play_c128", 1'b0, 1'b1, 2'b01);
    tick(72);
    winrnd = 1'b1;
    tick(10);
    winrnd = 1'b0;
    tick(46);
    checkOutput("play_c256", 1'b0, 1'b1, 2'b10);
    for (int i = 257; i < 384; i++) begin
      tick(1);
      checkOutput("play_on", 1'b0, 1'b1, 2'b10);
    end
    tick(1);
    checkOutput("play_c384", 1'b0, 1'b1, 2'b11);
    tick(127);
    checkOutput("play_c511", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("dark_entry_clr", 1'b1, 1'b0, 2'b00);
    tick(1);
    checkOutput("dark_clr_drop", 1'b0, 1'b0, 2'b00);

    // ~550 cycles after reset: 2-cycle winrnd pulse.
    tick(36);
    winrnd = 1'b1;
    tick(1);
    checkOutput("win_w0", 1'b0, 1'b1, 2'b11);
    tick(1);
    winrnd = 1'b0;
    checkOutput("win_w1", 1'b0, 1'b1, 2'b11);
    tick(62);
    checkOutput("win_w63", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("win_w64", 1'b0, 1'b0, 2'b11);
    tick(64);
    checkOutput("win_w128", 1'b0, 1'b1, 2'b11);
    // winrnd during WIN must not disturb the 1024-cycle duration.
    tick(372);
    winrnd = 1'b1;
    tick(5);
    winrnd = 1'b0;
    tick(518);
    checkOutput("win_w1023", 1'b0, 1'b0, 2'b11);
    tick(1);
    checkOutput("play2_c0", 1'b0, 1'b1, 2'b00);
    tick(511);
    checkOutput("play2_c511", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("dark2_entry_clr", 1'b1, 1'b0, 2'b00);

    // Long DARK wait: no timeout, no further clr.
    for (int i = 0; i < 1700; i++) begin
      tick(1);
      checkOutput("dark_hold", 1'b0, 1'b0, 2'b00);
    end
    winrnd = 1'b1;
    tick(1);
    winrnd = 1'b0;
    checkOutput("win3_w0", 1'b0, 1'b1, 2'b11);

    // Reset mid-WIN: immediate return to PLAY.
    tick(300);
    checkOutput("win3_w300", 1'b0, 1'b1, 2'b11);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_win", 1'b0, 1'b1, 2'b00);
    tick(2);
    rst = 1'b1;
    tick(511);
    checkOutput("rst_win_c511", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("rst_win_dark", 1'b1, 1'b0, 2'b00);

    // Go around once more and reset mid-PLAY.
    tick(10);
    winrnd = 1'b1;
    tick(1);
    winrnd = 1'b0;
    tick(1024);
    checkOutput("play4_c0", 1'b0, 1'b1, 2'b00);
    tick(300);
    checkOutput("play4_c300", 1'b0, 1'b1, 2'b10);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_play", 1'b0, 1'b1, 2'b00);
    tick(2);
    rst = 1'b1;
    tick(511);
    checkOutput("rst_play_c511", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("rst_play_dark", 1'b1, 1'b0, 2'b00);

    // Reset during the clr cycle: clr drops at once, DARK not retained.
    rst = 1'b0;
    #1;
    checkOutput("rst_on_clr", 1'b0, 1'b1, 2'b00);
    tick(1);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_clr_play_c1", 1'b0, 1'b1, 2'b00);

    // winrnd already high when DARK is entered: WIN on the following edge.
    tick(510);
    winrnd = 1'b1;
    checkOutput("late_c511", 1'b0, 1'b1, 2'b11);
    tick(1);
    checkOutput("late_dark_clr", 1'b1, 1'b0, 2'b00);
    tick(1);
    winrnd = 1'b0;
    checkOutput("late_win", 1'b0, 1'b1, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
